// File: rtl/counter_32bit_overflow.sv
// Free-running up-counter with a registered wrap indication.
// Define COUNTER_OV_STICKY_EN to make overflow sticky until reset.
module counter_32bit_overflow #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      STEP        = WIDTH'(1),
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    // One extra bit so the carry-out of the add is the wrap condition.
    logic [WIDTH:0] sum_c;

    assign sum_c = {1'b0, count} + {1'b0, STEP};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= RESET_VALUE;
            overflow <= 1'b0;
        end else begin
            count    <= sum_c[WIDTH-1:0];
`ifdef COUNTER_OV_STICKY_EN
            overflow <= overflow | sum_c[WIDTH];
`else
            overflow <= sum_c[WIDTH];
`endif
        end
    end

endmodule

// File: tb/tb_counter_32bit_overflow.sv
// Self-checking bench for counter_32bit_overflow against an arithmetic model.
module tb_counter_32bit_overflow;

`ifdef COUNTER_OV_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk;
    logic r32, r4, rw, r43, r8;
    logic [31:0] c32, cw;
    logic [3:0]  c4, c43;
    logic [7:0]  c8;
    logic        o32, o4, ow, o43, o8;

    int n_checks;
    int n_fail;

    counter_32bit_overflow u_d32 (.clk(clk), .reset(r32), .count(c32), .overflow(o32));
    counter_32bit_overflow #(.WIDTH(4)) u_d4 (.clk(clk), .reset(r4), .count(c4), .overflow(o4));
    counter_32bit_overflow #(.WIDTH(32), .RESET_VALUE(32'hFFFF_FFFE))
        u_dw (.clk(clk), .reset(rw), .count(cw), .overflow(ow));
    counter_32bit_overflow #(.WIDTH(4), .STEP(4'd3))
        u_d43 (.clk(clk), .reset(r43), .count(c43), .overflow(o43));
    counter_32bit_overflow #(.WIDTH(8), .STEP(8'd37), .RESET_VALUE(8'h5A))
        u_d8 (.clk(clk), .reset(r8), .count(c8), .overflow(o8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        r32 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (c32 !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%h exp=%h", c32, 32'd0); end
        n_checks++;
        if (o32 !== 1'b0) begin n_fail++; $display("FAIL reset_ov got=%b exp=0", o32); end
        @(negedge clk);
        r32 = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        n_checks++;
        if (c32 !== 32'd7) begin n_fail++; $display("FAIL pre_async_count got=%h exp=%h", c32, 32'd7); end
        #2 r32 = 1'b0;
        #1;
        n_checks++;
        if (c32 !== 32'd0) begin n_fail++; $display("FAIL async_reset_count got=%h exp=0", c32); end
        n_checks++;
        if (o32 !== 1'b0) begin n_fail++; $display("FAIL async_reset_ov got=%b exp=0", o32); end
    endtask

    task automatic test_count_up;
        @(negedge clk);
        r32 = 1'b1;
        #1;
        n_checks++;
        if (c32 !== 32'd0) begin n_fail++; $display("FAIL release_no_update got=%h exp=0", c32); end
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (c32 !== 32'(i) || o32 !== 1'b0) begin
                n_fail++;
                $display("FAIL count_up[%0d] got=%h/%b exp=%h/0", i, c32, o32, 32'(i));
            end
        end
    endtask

    task automatic test_wrap4;
        logic exp_ov;
        @(negedge clk);
        r4 = 1'b0;
        @(negedge clk);
        r4 = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk);
            #1;
            exp_ov = STICKY ? (i >= 16) : (i % 16 == 0);
            n_checks++;
            if (c4 !== 4'(i % 16) || o4 !== exp_ov) begin
                n_fail++;
                $display("FAIL wrap4[%0d] got=%0d/%b exp=%0d/%b", i, c4, o4, i % 16, exp_ov);
            end
        end
    endtask

    task automatic test_wrap32;
        logic [31:0] exp_c [3];
        logic        exp_o [3];
        exp_c[0] = 32'hFFFF_FFFF; exp_o[0] = 1'b0;
        exp_c[1] = 32'h0000_0000; exp_o[1] = 1'b1;
        exp_c[2] = 32'h0000_0001; exp_o[2] = STICKY;
        @(negedge clk);
        rw = 1'b0;
        #1;
        n_checks++;
        if (cw !== 32'hFFFF_FFFE || ow !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap32_reset got=%h/%b exp=fffffffe/0", cw, ow);
        end
        @(negedge clk);
        rw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (cw !== exp_c[i] || ow !== exp_o[i]) begin
                n_fail++;
                $display("FAIL wrap32[%0d] got=%h/%b exp=%h/%b", i, cw, ow, exp_c[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_step3;
        int m;
        bit seen;
        logic exp_ov;
        m = 0;
        seen = 1'b0;
        @(negedge clk);
        r43 = 1'b0;
        @(negedge clk);
        r43 = 1'b1;
        // 3,6,9,12,15,2,5,8
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            exp_ov = (m + 3 >= 16);
            m = (m + 3) % 16;
            if (exp_ov) seen = 1'b1;
            if (STICKY) exp_ov = seen;
            n_checks++;
            if (c43 !== 4'(m) || o43 !== exp_ov) begin
                n_fail++;
                $display("FAIL step3[%0d] got=%0d/%b exp=%0d/%b", i, c43, o43, m, exp_ov);
            end
        end
        @(negedge clk);
        r43 = 1'b0;
        #1;
        n_checks++;
        if (c43 !== 4'd0 || o43 !== 1'b0) begin
            n_fail++;
            $display("FAIL step3_clear got=%0d/%b exp=0/0", c43, o43);
        end
    endtask

    task automatic test_reset_during_pulse;
        @(negedge clk);
        r4 = 1'b0;
        @(negedge clk);
        r4 = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        n_checks++;
        if (c4 !== 4'd0 || o4 !== 1'b1) begin
            n_fail++;
            $display("FAIL pulse_setup got=%0d/%b exp=0/1", c4, o4);
        end
        #2 r4 = 1'b0;
        #1;
        n_checks++;
        if (c4 !== 4'd0 || o4 !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_reset got=%0d/%b exp=0/0", c4, o4);
        end
        @(negedge clk);
        r4 = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (c4 !== 4'd1 || o4 !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_after_release got=%0d/%b exp=1/0", c4, o4);
        end
    endtask

    task automatic test_random;
        int   m;
        bit   mo;
        bit   wrap;
        bit   rst;
        m  = 32'h5A;
        mo = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 15) == 0);
            r8  = ~rst;
            if (rst) begin
                m  = 32'h5A;
                mo = 1'b0;
                #1;
                n_checks++;
                if (c8 !== 8'(m) || o8 !== mo) begin
                    n_fail++;
                    $display("FAIL rand_reset[%0d] got=%h/%b exp=%h/%b", i, c8, o8, 8'(m), mo);
                end
            end
            @(posedge clk);
            #1;
            if (!rst) begin
                wrap = (m + 37 >= 256);
                m    = (m + 37) % 256;
                mo   = STICKY ? (mo | wrap) : wrap;
            end
            n_checks++;
            if (c8 !== 8'(m) || o8 !== mo) begin
                n_fail++;
                $display("FAIL rand[%0d] got=%h/%b exp=%h/%b", i, c8, o8, 8'(m), mo);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        r32 = 1'b0; r4 = 1'b0; rw = 1'b0; r43 = 1'b0; r8 = 1'b0;
        test_reset;
        test_count_up;
        test_wrap4;
        test_wrap32;
        test_step3;
        test_reset_during_pulse;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
